// File: rtl/nios2_pio_pkg.sv
// nios2_pio_pkg
//   Shared constants for the NIOS2 debounced PIO input controller:
//   Avalon register word addresses, debounce FSM state encoding and
//   the EDGE_TYPE parameter encodings.
package nios2_pio_pkg;

    // Avalon register word addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;  // debounced levels, RO
    localparam logic [1:0] ADDR_RAW  = 2'd1;  // synchronised levels, RO
    localparam logic [1:0] ADDR_MASK = 2'd2;  // irq enable, RW
    localparam logic [1:0] ADDR_EDGE = 2'd3;  // sticky edge flags, RW1C

    // Per-bit debounce FSM states
    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

    // EDGE_TYPE encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios2_pio_debounce_bit.sv
// nios2_pio_debounce_bit
//   One input bit: SYNC_STAGES-flop synchroniser followed by a debounce
//   FSM that accepts a new level only after it has been seen for
//   DEBOUNCE_CYCLES consecutive clocks.
// Ports
//   clk        in   system clock
//   reset_n    in   async active-low reset
//   raw        in   raw asynchronous input bit
//   level_sync out  synchronised, undebounced level
//   level      out  debounced level
//   flip       out  high in the cycle before level toggles (combinational)
module nios2_pio_debounce_bit
    import nios2_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level_sync,
    output logic level,
    output logic flip
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The STABLE cycle that first sees the mismatch is the first of the
    // DEBOUNCE_CYCLES qualifying cycles, so COUNT needs DEBOUNCE_CYCLES-1
    // more; cnt then runs 0..DEBOUNCE_CYCLES-2. This keeps the overall
    // raw-to-level latency at SYNC_STAGES + DEBOUNCE_CYCLES.
    localparam int LAST_INT = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_INT);
    localparam bit INSTANT = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q;
    db_state_e              state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   s;

    assign s          = sync_q[SYNC_STAGES-1];
    assign level_sync = s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            state  <= ST_STABLE;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            state  <= state_n;
            cnt    <= cnt_n;
            level  <= level ^ flip;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        flip    = 1'b0;
        case (state)
            ST_STABLE: begin
                if (s != level) begin
                    if (INSTANT) begin
                        flip = 1'b1;
                    end else begin
                        state_n = ST_COUNT;
                        cnt_n   = '0;
                    end
                end
            end
            ST_COUNT: begin
                if (s == level) begin
                    // glitch: input went back before qualifying
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    flip    = 1'b1;
                    state_n = ST_STABLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = ST_STABLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/nios2_pio_in_debounce_ctrl.sv
// nios2_pio_in_debounce_ctrl
//   Avalon-MM slave for debounced NIOS2 parallel inputs. Each bit is
//   synchronised and debounced independently; qualified edges of the
//   debounced level are captured in a sticky register which, under a
//   per-bit mask, drives a level interrupt.
// Ports
//   clk, reset_n          clock, async active-low reset
//   address, chipselect,
//   write_n, writedata    Avalon-MM slave write/select inputs
//   in_port               raw asynchronous inputs
//   readdata              registered read data, 1-cycle latency
//   irq                   |(edge_capture & irq_mask)
module nios2_pio_in_debounce_ctrl
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw_sync;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rd_sel;
    logic             write;
    logic             unused_wdata;

    // Bits of writedata above WIDTH have no register behind them.
    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios2_pio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset_n   (reset_n),
            .raw       (in_port[i]),
            .level_sync(raw_sync[i]),
            .level     (debounced[i]),
            .flip      (flip[i])
        );
    end

    // flip is the pre-edge strobe, so the capture bit sets on the same
    // clock the debounced level changes. The new level is ~debounced.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISE: edge_hit = flip & ~debounced;
            EDGE_FALL: edge_hit = flip &  debounced;
            default:   edge_hit = flip;
        endcase
    end

    assign write    = chipselect & ~write_n;
    assign edge_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (write && address == ADDR_MASK)
                irq_mask <= writedata[WIDTH-1:0];
            // set after clear: a same-cycle set wins
            edge_capture <= (edge_capture & ~edge_clr) | edge_hit;
        end
    end

    always_comb begin
        rd_sel = '0;
        case (address)
            ADDR_DATA: rd_sel = debounced;
            ADDR_RAW:  rd_sel = raw_sync;
            ADDR_MASK: rd_sel = irq_mask;
            ADDR_EDGE: rd_sel = edge_capture;
            default:   rd_sel = '0;
        endcase
    end

    // read path runs every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else
            readdata <= 32'(rd_sel);
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios2_pio_in_debounce_ctrl.sv
// tb_nios2_pio_in_debounce_ctrl
//   Directed scenarios followed by random traffic. A reference model built
//   from the register-map and debounce rules (a level is accepted once the
//   FSM has seen it, different from the current level, on D consecutive
//   clocks) predicts readdata and irq; every cycle is compared.
module tb_nios2_pio_in_debounce_ctrl;

    localparam int W = 4;
    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [W-1:0] in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    nios2_pio_in_debounce_ctrl #(
        .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [W-1:0] m_pipe [S];   // synchroniser contents, [S-1] is what the FSM sees
    logic [W-1:0] m_seen [$];   // last D levels seen by the FSM since reset
    logic [W-1:0] m_d, m_cap, m_mask;
    logic [31:0]  m_rd;

    task automatic model_reset();
        for (int j = 0; j < S; j++) m_pipe[j] = '0;
        m_seen.delete();
        m_d = '0; m_cap = '0; m_mask = '0; m_rd = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] s_cur, flipv, clr;
        bit all_diff;
        s_cur = m_pipe[S-1];
        m_seen.push_back(s_cur);
        if (m_seen.size() > D) void'(m_seen.pop_front());
        flipv = '0;
        if (m_seen.size() == D) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (m_seen[k]) if (m_seen[k][i] == m_d[i]) all_diff = 1'b0;
                flipv[i] = all_diff;
            end
        end
        case (address)
            2'd0:    m_rd = {28'b0, m_d};
            2'd1:    m_rd = {28'b0, s_cur};
            2'd2:    m_rd = {28'b0, m_mask};
            default: m_rd = {28'b0, m_cap};
        endcase
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
        m_cap = (m_cap & ~clr) | (flipv & ~m_d);
        m_d   = m_d ^ flipv;
        for (int j = S - 1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
        m_pipe[0] = in_port;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: model advances on the edge, outputs checked on the falling edge
    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        chk("rd_model", readdata, m_rd);
        chk("irq_model", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
    endtask

    task automatic cycn(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cyc();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        model_reset();
        cycn(3);
        chk("reset_rd", readdata, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        cycn(2);

        // 1. clean rise of bit 0; DATA reflects d one read-latency later
        in_port = 4'h1;
        cycn(6);
        chk("t1_data_early", readdata, 32'h0);
        cyc();
        chk("t1_data", readdata, 32'h1);
        address = 2'd3;
        cyc();
        chk("t1_edgecap", readdata, 32'h1);
        chk("t1_irq", {31'b0, irq}, 32'h0);

        // 2. glitch on bit 2: three clocks high is one short
        address = 2'd0;
        in_port = 4'h5;
        cycn(3);
        in_port = 4'h1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("t2_data", readdata, 32'h1);
        end
        address = 2'd3;
        cyc();
        chk("t2_edgecap", readdata, 32'h1);

        // 3. interrupt path
        wr(2'd3, 32'hF);
        wr(2'd2, 32'hF);
        chk("t3_irq_idle", {31'b0, irq}, 32'h0);
        in_port = 4'h9;
        cycn(5);
        chk("t3_irq_before", {31'b0, irq}, 32'h0);
        cyc();
        chk("t3_irq_set", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        chk("t3_irq_keep", {31'b0, irq}, 32'h1);
        wr(2'd3, 32'h8);
        chk("t3_irq_clr", {31'b0, irq}, 32'h0);

        // 4. W1C of bit 0 on the very clock its rising edge is captured
        in_port = 4'h8;
        cycn(8);
        in_port = 4'h9;
        cycn(5);
        wr(2'd3, 32'h1);
        address = 2'd3;
        cyc();
        chk("t4_collision", readdata, 32'h1);
        chk("t4_irq", {31'b0, irq}, 32'h1);

        // 5. reset in the middle of a bit-1 transition
        address = 2'd0;
        in_port = 4'hB;
        cycn(3);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_rd", readdata, 32'h0);
        chk("t5_rst_irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        cycn(2);
        reset_n = 1'b1;
        cycn(6);
        chk("t5_data_early", readdata, 32'h0);
        cyc();
        chk("t5_data", readdata, 32'hB);

        // 6. read latency and zero upper bits
        in_port = 4'h2;
        cycn(3);
        chk("t6_data_still", readdata, 32'hB);
        address = 2'd1;
        cyc();
        chk("t6_raw", readdata, 32'h2);
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            cyc();
            chk("t6_upper_zero", {4'h0, readdata[31:4]}, 32'h0);
        end

        // random traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) in_port = W'($urandom);
            address = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                chipselect = 1'($urandom);
                write_n    = 1'($urandom);
                writedata  = $urandom;
            end else begin
                chipselect = 1'b0; write_n = 1'b1; writedata = '0;
            end
            cyc();
            if (it == 300) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                chk("rand_rst_rd", readdata, 32'h0);
                @(negedge clk);
                reset_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
